// File: rtl/keypad_encoder_if.sv
// Keypad encoder port bundle: raw button inputs toward the encoder and the
// registered strobes / key code coming back.
interface keypad_encoder_if;
  logic [0:9] btn_digit;
  logic       btn_clear;
  logic       btn_next;
  logic [0:9] IO;
  logic       clear;
  logic       prox;
  logic [3:0] key_code;
  logic       multi_key;

  modport master (
    output btn_digit, btn_clear, btn_next,
    input  IO, clear, prox, key_code, multi_key
  );

  modport slave (
    input  btn_digit, btn_clear, btn_next,
    output IO, clear, prox, key_code, multi_key
  );
endinterface

// File: rtl/keypad_encoder.sv
// Keypad encoder: synchronizes 12 raw buttons, debounces a single winning key,
// emits one registered strobe per accepted press and ignores holds/bounces
// until the keypad has been quiet long enough.
module keypad_encoder #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  keypad_encoder_if.slave  kp
);

  // Key indices: 0-9 digits, 10 clear, 11 next.
  localparam logic [3:0] KEY_CLEAR = 4'd10;
  localparam logic [3:0] KEY_NEXT  = 4'd11;
  localparam logic [7:0] CNT_EMIT  = 8'(DEBOUNCE_CYCLES - 1);
  // The HOLD sample that saw the keypad quiet is the first quiet cycle, so
  // RELEASE itself only has to see DEBOUNCE_CYCLES-1 more.
  localparam logic [7:0] CNT_QUIET = 8'(DEBOUNCE_CYCLES - 2);

  typedef enum logic [2:0] {IDLE, DEBOUNCE, EMIT, HOLD, RELEASE} state_t;

  state_t      state_q, state_d;
  logic [11:0] raw;
  logic [11:0] sync1_q, sync1_d;
  logic [11:0] sync2_q, sync2_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  key_q, key_d;
  logic [3:0]  code_q, code_d;
  logic [0:9]  io_q, io_d;
  logic        clear_q, clear_d;
  logic        prox_q, prox_d;
  logic        multi_q, multi_d;
  logic        armed_q, armed_d;

  logic [3:0]  win_code;
  logic [3:0]  n_hi;
  logic        win_vld;
  logic        multi_hit;
  logic        any_key;

  // Pack the raw buttons into one vector indexed by key number.
  always_comb begin
    raw = '0;
    for (int i = 0; i < 10; i++) raw[i] = kp.btn_digit[i];
    raw[10] = kp.btn_clear;
    raw[11] = kp.btn_next;
  end

  // Pick the winning key from the synchronized copy: clear dominates,
  // otherwise exactly one non-clear key wins and two or more is a conflict.
  always_comb begin
    win_code  = '0;
    win_vld   = 1'b0;
    multi_hit = 1'b0;
    n_hi      = '0;
    for (int i = 0; i < 12; i++) begin
      if (i != 10 && sync2_q[i]) begin
        n_hi     = n_hi + 4'd1;
        win_code = 4'(i);
      end
    end
    if (sync2_q[10]) begin
      win_code = KEY_CLEAR;
      win_vld  = 1'b1;
    end else if (n_hi == 4'd1) begin
      win_vld  = 1'b1;
    end else if (n_hi >= 4'd2) begin
      multi_hit = 1'b1;
    end
    any_key = |sync2_q;
  end

  // Synchronizer shift, next state, counters and strobe decode.
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    code_d  = code_q;
    io_d    = '0;
    clear_d = 1'b0;
    prox_d  = 1'b0;
    multi_d = 1'b0;
    armed_d = armed_q;
    // A fully quiet keypad re-arms the conflict pulse.
    if (!any_key) armed_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          key_d   = win_code;
          cnt_d   = '0;
          state_d = DEBOUNCE;
        end else if (multi_hit && armed_q) begin
          multi_d = 1'b1;
          armed_d = 1'b0;
        end
      end
      DEBOUNCE: begin
        if (!win_vld || win_code != key_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_EMIT) begin
          // Strobes and key_code are registered, so they are decoded on the
          // way into EMIT and are visible exactly while EMIT is current.
          state_d = EMIT;
          code_d  = key_q;
          for (int i = 0; i < 10; i++) begin
            if (key_q == 4'(i)) io_d[i] = 1'b1;
          end
          clear_d = (key_q == KEY_CLEAR);
          prox_d  = (key_q == KEY_NEXT);
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      EMIT: state_d = HOLD;
      HOLD: begin
        if (!any_key) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end
      end
      RELEASE: begin
        if (any_key)                 state_d = HOLD;
        else if (cnt_q == CNT_QUIET) state_d = IDLE;
        else                         cnt_d   = cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset clears everything, truncating strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q   <= '0;
      key_q   <= '0;
      code_q  <= '0;
      io_q    <= '0;
      clear_q <= 1'b0;
      prox_q  <= 1'b0;
      multi_q <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      code_q  <= code_d;
      io_q    <= io_d;
      clear_q <= clear_d;
      prox_q  <= prox_d;
      multi_q <= multi_d;
      armed_q <= armed_d;
    end
  end

  assign kp.IO        = io_q;
  assign kp.clear     = clear_q;
  assign kp.prox      = prox_q;
  assign kp.key_code  = code_q;
  assign kp.multi_key = multi_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// Testbench for keypad_encoder: directed scenarios with literal expectations
// plus randomized press/bounce/release sessions against a timestamp model.
module tb_keypad_encoder;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  keypad_encoder_if kp ();

  keypad_encoder #(.DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kp)
  );

  // Drive values applied at the next falling edge.
  logic [0:9] d_digit = '0;
  logic       d_clear = 1'b0;
  logic       d_next  = 1'b0;
  logic       d_rst   = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  // Model: synchronizer copy plus accept/lock bookkeeping by edge number.
  logic [11:0] m_s1, m_s2;
  bit          m_active;
  int          m_cand, m_cand_start, m_lock_edge, m_quiet, m_edge;
  bit          m_armed;
  logic [0:9]  e_io;
  logic        e_clear, e_prox, e_multi;
  logic [3:0]  e_code;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic int winner(input logic [11:0] s);
    int n = 0;
    int idx = 15;
    if (s[10]) return 10;
    for (int i = 0; i < 12; i++) if (i != 10 && s[i]) begin n++; idx = i; end
    if (n == 1) return idx;
    if (n >= 2) return 14;
    return 15;
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0;
    m_active = 1'b1; m_cand = -1; m_cand_start = 0;
    m_lock_edge = -100; m_quiet = 0; m_edge = 0; m_armed = 1'b1;
    e_io = '0; e_clear = 1'b0; e_prox = 1'b0; e_multi = 1'b0; e_code = '0;
  endtask

  task automatic model_edge();
    logic [11:0] s;
    int w;
    bit any;
    m_edge++;
    s = m_s2;
    m_s2 = m_s1;
    for (int i = 0; i < 10; i++) m_s1[i] = d_digit[i];
    m_s1[10] = d_clear;
    m_s1[11] = d_next;
    e_io = '0; e_clear = 1'b0; e_prox = 1'b0; e_multi = 1'b0;
    w = winner(s);
    any = (s != 12'd0);
    if (m_active) begin
      if (m_cand < 0) begin
        if (w <= 11) begin
          m_cand = w; m_cand_start = m_edge;
        end else if (w == 14 && m_armed) begin
          e_multi = 1'b1; m_armed = 1'b0;
        end
      end else if (w != m_cand) begin
        m_cand = -1;
      end else if (m_edge - m_cand_start == D) begin
        if (m_cand < 10) e_io[m_cand] = 1'b1;
        else if (m_cand == 10) e_clear = 1'b1;
        else e_prox = 1'b1;
        e_code = 4'(m_cand);
        m_active = 1'b0; m_lock_edge = m_edge; m_quiet = 0; m_cand = -1;
      end
    end else if (m_edge > m_lock_edge + 1) begin
      m_quiet = any ? 0 : m_quiet + 1;
      if (m_quiet == D) m_active = 1'b1;
    end
    if (!any) m_armed = 1'b1;
  endtask

  task automatic compare(input string tag);
    chk({tag, ".io"},       32'(kp.IO),        32'(e_io));
    chk({tag, ".clear"},    32'(kp.clear),     32'(e_clear));
    chk({tag, ".prox"},     32'(kp.prox),      32'(e_prox));
    chk({tag, ".multi"},    32'(kp.multi_key), 32'(e_multi));
    chk({tag, ".key_code"}, 32'(kp.key_code),  32'(e_code));
  endtask

  // One clock: apply inputs at the falling edge, check after the rising edge.
  task automatic step();
    @(negedge clk);
    kp.btn_digit = d_digit;
    kp.btn_clear = d_clear;
    kp.btn_next  = d_next;
    rst_n        = d_rst;
    if (!d_rst) begin
      model_reset();
      #1 compare("rst_async");
    end
    @(posedge clk);
    if (d_rst) model_edge();
    #1 compare("cyc");
  endtask

  task automatic set_keys(input logic [11:0] k);
    for (int i = 0; i < 10; i++) d_digit[i] = k[i];
    d_clear = k[10];
    d_next  = k[11];
  endtask

  task automatic settle();
    set_keys(12'd0);
    for (int i = 0; i < 14; i++) step();
  endtask

  initial begin
    logic [11:0] keys;
    int r;
    kp.btn_digit = '0;
    kp.btn_clear = 1'b0;
    kp.btn_next  = 1'b0;
    model_reset();

    // Reset state.
    d_rst = 1'b0;
    step(); step();
    chk("reset_io", 32'(kp.IO), 32'd0);
    chk("reset_code", 32'(kp.key_code), 32'd0);
    d_rst = 1'b1;
    settle();

    // Digit 7 held: strobe only after edge 6, key_code 7, nothing more.
    set_keys(12'h080);
    for (int k = 0; k < 20; k++) begin
      step();
      chk("s7_io7", 32'(kp.IO[7]), 32'(k == 6));
      if (k == 6) chk("s7_code", 32'(kp.key_code), 32'd7);
    end
    settle();

    // Digit 3 toggling for 10 cycles, then held: one strobe 6 edges later.
    for (int k = 0; k < 28; k++) begin
      set_keys((k >= 10 || (k % 2) == 0) ? 12'h008 : 12'h000);
      step();
      chk("s3_io3", 32'(kp.IO[3]), 32'(k == 16));
    end
    settle();

    // Digit 2 with next: one conflict pulse, no strobe, key_code stays 3.
    set_keys(12'h804);
    for (int k = 0; k < 12; k++) begin
      step();
      chk("smk_multi", 32'(kp.multi_key), 32'(k == 2));
      chk("smk_prox", 32'(kp.prox), 32'd0);
      chk("smk_code", 32'(kp.key_code), 32'd3);
    end
    settle();

    // Clear with digit 5: clear wins.
    set_keys(12'h420);
    for (int k = 0; k < 12; k++) begin
      step();
      chk("sclr_clear", 32'(kp.clear), 32'(k == 6));
      chk("sclr_io", 32'(kp.IO), 32'd0);
      if (k >= 6) chk("sclr_code", 32'(kp.key_code), 32'd10);
    end
    settle();

    // Digit 4 press, release that bounces inside RELEASE: single strobe.
    for (int k = 0; k < 30; k++) begin
      set_keys((k < 10 || k == 12 || k == 14 || k == 16) ? 12'h010 : 12'h000);
      step();
      chk("sbnc_io4", 32'(kp.IO[4]), 32'(k == 6));
    end
    set_keys(12'h002);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("sbnc_io1", 32'(kp.IO[1]), 32'(k == 6));
    end
    settle();

    // Next pressed, reset during EMIT, key still held afterwards.
    set_keys(12'h800);
    for (int k = 0; k <= 6; k++) step();
    chk("srst_prox_emit", 32'(kp.prox), 32'd1);
    d_rst = 1'b0;
    step();
    chk("srst_prox_cut", 32'(kp.prox), 32'd0);
    step();
    d_rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("srst_prox_again", 32'(kp.prox), 32'(k == 6));
    end
    settle();

    // Randomized sessions: single keys, conflicts, bounce and stray resets.
    for (int s = 0; s < 80; s++) begin
      r = $urandom_range(0, 9);
      keys = '0;
      if (r < 6) keys[$urandom_range(0, 11)] = 1'b1;
      else if (r < 8) begin
        keys[$urandom_range(0, 11)] = 1'b1;
        keys[$urandom_range(0, 11)] = 1'b1;
      end else if (r < 9) keys = 12'($urandom);
      for (int i = 0, n = $urandom_range(0, 4); i < n; i++) begin
        set_keys(keys & 12'($urandom)); step();
      end
      for (int i = 0, n = $urandom_range(0, 12); i < n; i++) begin
        set_keys(keys);
        d_rst = ($urandom_range(0, 40) != 0);
        step();
        d_rst = 1'b1;
      end
      for (int i = 0, n = $urandom_range(0, 4); i < n; i++) begin
        set_keys(keys & 12'($urandom)); step();
      end
      set_keys(12'd0);
      for (int i = 0, n = $urandom_range(0, 14); i < n; i++) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/keypad_encoder.md
KEYPAD_ENCODER -- requirements
Module: keypad_encoder

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning the number of consecutive stable cycles required to accept a press or a release (legal range 2..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port btn_digit, input, [0:9]: raw active-high digit buttons, bit n = key n, asynchronous to clk.
REQ-005 The block SHALL have port btn_clear, input, 1 bit: raw active-high clear button, asynchronous to clk.
REQ-006 The block SHALL have port btn_next, input, 1 bit: raw active-high next-field button, asynchronous to clk.
REQ-007 The block SHALL have port IO, output, [0:9]: one-hot digit strobe, bit n high one cycle per accepted press of key n.
REQ-008 The block SHALL have port clear, output, 1 bit: one-cycle strobe per accepted clear press.
REQ-009 The block SHALL have port prox, output, 1 bit: one-cycle strobe per accepted next press.
REQ-010 The block SHALL have port key_code, output, 4 bits: last accepted key (0-9 digit, 10 clear, 11 next).
REQ-011 The block SHALL have port multi_key, output, 1 bit: one-cycle pulse flagging a rejected simultaneous press.

Function
REQ-012 All 12 raw inputs SHALL pass through a 2-flop synchronizer; all logic SHALL use only the synchronized copies.
REQ-013 The FSM SHALL have states IDLE, DEBOUNCE, EMIT, HOLD, RELEASE.
REQ-014 IDLE: synced clear high (with any other key) -> latch key 10, go DEBOUNCE with counter 0.
REQ-015 IDLE: otherwise, exactly one of the 11 non-clear synced keys high -> latch its index, go DEBOUNCE with counter 0.
REQ-016 IDLE: two or more non-clear keys high with clear low -> pulse multi_key for one cycle, stay IDLE; multi_key SHALL NOT re-pulse until all keys have been low for at least one cycle.
REQ-017 DEBOUNCE: latched key still the sole winner per REQ-014/015 -> counter increments.
REQ-018 DEBOUNCE: counter reaching DEBOUNCE_CYCLES-1 with the key still valid -> go EMIT.
REQ-019 DEBOUNCE: latched key drops, or a different key becomes winner -> go IDLE with no output.
REQ-020 EMIT (exactly one cycle): assert the strobe for the latched key (IO[n], clear or prox) and load key_code, then go HOLD.
REQ-021 HOLD: stay while any synced key is high; all keys low -> go RELEASE with counter 0.
REQ-022 RELEASE: all keys low for DEBOUNCE_CYCLES consecutive cycles -> IDLE; any key high -> back to HOLD, so bounce and held keys never re-emit.
REQ-023 At most one of IO[0:9], clear, prox SHALL be high in any cycle; all strobes are registered outputs.
REQ-024 Latency SHALL be fixed: raw press first sampled at edge 0 and held clean -> strobe high from edge DEBOUNCE_CYCLES+2 to edge DEBOUNCE_CYCLES+3.
REQ-025 Minimum spacing between two accepted presses SHALL be 2*DEBOUNCE_CYCLES+2 cycles.
REQ-026 key_code SHALL change only in EMIT and otherwise hold its value.

Reset
REQ-027 rst_n low SHALL immediately force IDLE and set all synchronizer flops, counter, IO, clear, prox, multi_key and key_code to 0.
REQ-028 Reset asserted in any state (including EMIT) SHALL truncate any in-progress strobe within the same cycle.
REQ-029 A key held across reset release SHALL be treated as a new press and emit after normal debounce.

Verification
REQ-030 Scenario: DEBOUNCE_CYCLES=4, btn_digit[7] raised before edge 0 and held -> IO[7]=1 only between edges 6 and 7, key_code=7, no further strobe while held.
REQ-031 Scenario: btn_digit[3] toggles each cycle for 10 cycles then holds high -> exactly one IO[3] strobe, occurring 6 edges after the final stable sample.
REQ-032 Scenario: btn_digit[2] and btn_next raised together -> one multi_key pulse, no strobe, key_code unchanged.
REQ-033 Scenario: btn_clear and btn_digit[5] raised together -> one clear strobe, key_code=10, no IO strobe.
REQ-034 Scenario: release of a key bouncing 3 cycles inside RELEASE -> no second strobe; next clean press of key 1 -> IO[1] strobe.
REQ-035 Scenario: rst_n pulsed low during EMIT of btn_next -> prox drops immediately, all outputs 0; if the key is still held after release, prox pulses after debounce.
